rv_iopmp_cfg_loader: RTL and testbench
======================================

# rv_iopmp_cfg_loader

Boot-time configuration initiator for the RISC-V IOPMP. On a start pulse it walks a table of (address, data) pairs held in a single-port SRAM and issues one register-interface write per pair into the IOPMP register map. It optionally reads each register back to check the value, then reports done or error. It drives the same register interface that the regmap wrapper receives, so the IOPMP can be programmed without a bus master.

## Interface
Parameters:
- `NUM_WORDS`, 64, SRAM table depth in entries; must be ≥2.
- `REG_ADDR_WIDTH`, 32, register interface address width.
- `REG_DATA_WIDTH`, 32, register interface data width; fixed at 32.
- `VERIFY`, 1, when 1 every write is followed by a readback compare.

Ports:
- Reset is synchronous and active-high; one clock. Both are listed first below.
- `clk_i`  in  1  rising-edge clock.
- `rst_i`  in  1  synchronous active-high reset.
- `start_i`  in  1  start pulse. Sampled only in IDLE.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when a run ends, whether it succeeds or aborts.
- `error_o`  out  1  sticky run-failed flag. Cleared on the next accepted start.
- `err_idx_o`  out  $clog2(NUM_WORDS)  table index of the failing entry.
- `count_o`  out  $clog2(NUM_WORDS+1)  number of entries completed in the current or last run.
- `mem_req_o`  out  1  SRAM read request.
- `mem_addr_o`  out  $clog2(NUM_WORDS)  SRAM word index.
- `mem_rdata_i`  in  64  SRAM read data, valid one cycle after `mem_req_o`.
- `reg_valid_o`  out  1  register request valid.
- `reg_write_o`  out  1  1 = write, 0 = read.
- `reg_addr_o`  out  REG_ADDR_WIDTH  byte address.
- `reg_wdata_o`  out  32  write data.
- `reg_wstrb_o`  out  4  write strobe.
- `reg_ready_i`  in  1  request accepted and response valid this cycle.
- `reg_rdata_i`  in  32  read data, qualified by `reg_ready_i`.
- `reg_error_i`  in  1  access error, qualified by `reg_ready_i`.

## Operation
SRAM entry format (64 bits):
- [63:32] write data.
- [31:2] register address bits [31:2]. The issued address is {word[31:2], 2'b00}, zero-extended to REG_ADDR_WIDTH.
- [1] reserved, ignored.
- [0] LAST: this is the final entry.

State machine:
- IDLE: if `start_i` is high, clear `idx`, `count_o`, `error_o` and `err_idx_o`, then go to FETCH.
- FETCH: `mem_req_o`=1, `mem_addr_o`=`idx`. Go to WAIT.
- WAIT: capture `mem_rdata_i` into the data, address and last registers. Go to WRITE.
- WRITE: drive `reg_valid_o`=1, `reg_write_o`=1, `reg_wstrb_o`=4'hF.
  - Wait for `reg_ready_i`.
  - If `reg_error_i` is high on that ready, go to ABORT.
  - Otherwise go to READ if VERIFY=1, else NEXT.
- READ: drive `reg_valid_o`=1, `reg_write_o`=0, `reg_wstrb_o`=0, same address.
  - On `reg_ready_i`, a read is a failure if `reg_error_i` is high or `reg_rdata_i` ≠ the captured data. Failure goes to ABORT; otherwise go to NEXT.
- NEXT: increment `count_o`.
  - If LAST was set or `idx`==NUM_WORDS-1, go to DONE. The index never wraps to 0.
  - Otherwise increment `idx` and go to FETCH.
- DONE: `done_o`=1 for one cycle, then go to IDLE.
- ABORT: `error_o`=1, `err_idx_o`=`idx`, `done_o`=1 for one cycle, then go to IDLE. `count_o` is not incremented for the failing entry.

Rules:
- Request hold: while `reg_valid_o` is high and `reg_ready_i` is low, `reg_valid_o`, `reg_write_o`, `reg_addr_o`, `reg_wdata_o` and `reg_wstrb_o` hold stable. `reg_valid_o` does not drop before ready.
- Outputs outside WRITE/READ: `reg_valid_o`=0, `reg_wstrb_o`=0. Address and data may retain their last values.
- `start_i` while busy is ignored.
- `start_i` in the same cycle as DONE or ABORT is ignored; the block is still busy in that cycle.

## Timing
- Reset values: all outputs are 0; the state is IDLE.
- Reset during any state: on the next cycle the block is in IDLE, `reg_valid_o`=0 and `mem_req_o`=0, and there is no done pulse.
- Start latency: `start_i` is sampled at edge 0, and FETCH is the cycle after edge 0.
- Per-entry cost with zero-wait ready:
  - VERIFY=1: 5 cycles (FETCH, WAIT, WRITE, READ, NEXT).
  - VERIFY=0: 4 cycles.
  - Each stall cycle with `reg_ready_i` low adds 1 cycle.
- N entries with VERIFY=1 and zero wait: `done_o` is high in cycle 5N+1 after the start edge.
- `busy_o` falls in the cycle after `done_o`.

## Test plan
- Three-entry table, LAST set at idx 2, VERIFY=1, `reg_ready_i` tied high, readback echoes the written data:
  - Writes to 0x00000000, 0x00000800 and 0x00000804 with the entry data, each followed by a read of the same address.
  - `done_o` pulses in cycle 16, `count_o`=3, `error_o`=0.
- `reg_ready_i` held low for 3 cycles during the WRITE of entry 0:
  - `reg_valid_o`, `reg_addr_o` and `reg_wdata_o` are stable for 4 cycles, and exactly one write is accepted.
- `reg_error_i`=1 on the write of entry 1 in a 4-entry table:
  - No request is issued for entries 2 and 3.
  - `error_o`=1, `err_idx_o`=1, `count_o`=1, one `done_o` pulse.
- Readback of entry 0 returns 0xDEADBEEF against written 0x00000001:
  - `error_o`=1, `err_idx_o`=0, `count_o`=0.
- NUM_WORDS=4, no LAST bit anywhere, VERIFY=0:
  - 4 writes at idx 0–3, `count_o`=4, `done_o` pulses in cycle 17.
  - No fetch of idx 0 after the fetch of idx 3.
- `rst_i` pulsed during WRITE of entry 1 while `reg_ready_i` is low:
  - Next cycle `reg_valid_o`=0 and `busy_o`=0, and no `done_o` pulse.
  - A new start restarts at idx 0 with `count_o`=0.

Source files
------------

// File: rtl/rv_iopmp_cfg_loader.sv
// Boot-time IOPMP configurator: walks an SRAM table of (addr,data) pairs and writes each into the register map.
// Latency: start to FETCH is 1 cycle; each entry costs 5 cycles (VERIFY=1) or 4 (VERIFY=0) plus register stalls.
// Backpressure: a register request is held stable until reg_ready_i; start_i is ignored while busy.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i                      start pulse, sampled only while idle
//   busy_o, done_o, error_o      run status; done_o is a one-cycle pulse, error_o is sticky until next start
//   err_idx_o, count_o           failing table index, entries completed in the current or last run
//   mem_req_o/addr_o/rdata_i     single-port table SRAM, read data one cycle after the request
//   reg_*                        register request channel into the IOPMP register map
module rv_iopmp_cfg_loader #(
    parameter int NUM_WORDS      = 64,
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int VERIFY         = 1,
    localparam int IW            = $clog2(NUM_WORDS),
    localparam int CW            = $clog2(NUM_WORDS + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic [IW-1:0]             err_idx_o,
    output logic [CW-1:0]             count_o,
    output logic                      mem_req_o,
    output logic [IW-1:0]             mem_addr_o,
    input  logic [63:0]               mem_rdata_i,
    output logic                      reg_valid_o,
    output logic                      reg_write_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_o,
    output logic [REG_DATA_WIDTH-1:0] reg_wdata_o,
    output logic [3:0]                reg_wstrb_o,
    input  logic                      reg_ready_i,
    input  logic [REG_DATA_WIDTH-1:0] reg_rdata_i,
    input  logic                      reg_error_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ABORT = 3'd7;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

    logic [2:0]                state_q;
    logic [IW-1:0]             idx_q;
    logic [CW-1:0]             count_q;
    logic                      error_q;
    logic [IW-1:0]             err_idx_q;
    logic [REG_ADDR_WIDTH-1:0] addr_q;
    logic [REG_DATA_WIDTH-1:0] data_q;
    logic                      last_q;

    // Table entry decode: address is word aligned, bit 1 is reserved.
    logic [31:0]               entry_addr;
    logic                      unused_rsv_bit;

    assign entry_addr     = {mem_rdata_i[31:2], 2'b00};
    assign unused_rsv_bit = mem_rdata_i[1];

    // Readback failure: bus error or data disagreeing with what was written.
    logic rd_fail;
    assign rd_fail = reg_error_i || (reg_rdata_i != data_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        idx_q     <= '0;
                        count_q   <= '0;
                        error_q   <= 1'b0;
                        err_idx_q <= '0;
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // SRAM data for the FETCH request is valid in this cycle.
                    addr_q  <= REG_ADDR_WIDTH'(entry_addr);
                    data_q  <= mem_rdata_i[32 +: REG_DATA_WIDTH];
                    last_q  <= mem_rdata_i[0];
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (reg_ready_i) begin
                        if (reg_error_i) begin
                            error_q   <= 1'b1;
                            err_idx_q <= idx_q;
                            state_q   <= S_ABORT;
                        end else if (VERIFY != 0) begin
                            state_q <= S_READ;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_READ: begin
                    if (reg_ready_i) begin
                        if (rd_fail) begin
                            error_q   <= 1'b1;
                            err_idx_q <= idx_q;
                            state_q   <= S_ABORT;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    count_q <= count_q + CW'(1);
                    // Stop at the end of the table rather than wrapping to entry 0.
                    if (last_q || (idx_q == LAST_IDX)) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_ABORT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Request fields come straight from registers captured in WAIT, so they
    // stay stable for as long as WRITE/READ is stalled.
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE) || (state_q == S_ABORT);
    assign error_o     = error_q;
    assign err_idx_o   = err_idx_q;
    assign count_o     = count_q;
    assign mem_req_o   = (state_q == S_FETCH);
    assign mem_addr_o  = idx_q;
    assign reg_valid_o = (state_q == S_WRITE) || (state_q == S_READ);
    assign reg_write_o = (state_q == S_WRITE);
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = data_q;
    assign reg_wstrb_o = (state_q == S_WRITE) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_rv_iopmp_cfg_loader.sv
// Bench for rv_iopmp_cfg_loader: one VERIFY=1 instance (64 entries) and one VERIFY=0 instance (4 entries).
// Scenarios are table driven; stall, reset-in-flight and table-end cases are hand sequences.
// Register slaves and SRAMs are simple bench models.
module tb_rv_iopmp_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        int n;
        int last_at;
        int err_wr;
        bit bad_rd;
        bit poke;
        int exp_count;
        bit exp_err;
        int exp_err_idx;
        int exp_done;
        int exp_txns;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] adr [0:3] = '{32'h0000_0000, 32'h0000_0800, 32'h0000_0804, 32'h0000_0808};
    logic [31:0] dat [0:3] = '{32'h0000_0001, 32'hA5A5_0002, 32'h1234_5603, 32'hCAFE_0004};

    // ---------------- instance A: VERIFY=1, 64 entries ----------------
    logic        rst_a, start_a;
    logic        a_busy, a_done, a_error;
    logic [5:0]  a_err_idx;
    logic [6:0]  a_count;
    logic        a_mem_req;
    logic [5:0]  a_mem_addr;
    logic [63:0] a_mem_rdata;
    logic        a_valid, a_write;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_wstrb;
    logic        a_ready, a_rerr;

    logic        a_hold = 1'b0;
    logic        a_err_en = 1'b0;
    logic [31:0] a_err_addr = 32'h0;
    logic        a_bad_rd = 1'b0;
    logic [63:0] sram_a [0:63];
    logic [31:0] regs_a [0:1023];
    txn_t        log_a [$];

    rv_iopmp_cfg_loader #(.NUM_WORDS(64), .VERIFY(1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start_a),
        .busy_o(a_busy), .done_o(a_done), .error_o(a_error),
        .err_idx_o(a_err_idx), .count_o(a_count),
        .mem_req_o(a_mem_req), .mem_addr_o(a_mem_addr), .mem_rdata_i(a_mem_rdata),
        .reg_valid_o(a_valid), .reg_write_o(a_write), .reg_addr_o(a_addr),
        .reg_wdata_o(a_wdata), .reg_wstrb_o(a_wstrb), .reg_ready_i(a_ready),
        .reg_rdata_i(a_rdata), .reg_error_i(a_rerr)
    );

    assign a_ready = !a_hold;
    assign a_rerr  = a_err_en && a_valid && a_write && (a_addr == a_err_addr);
    assign a_rdata = a_bad_rd ? 32'hDEADBEEF : regs_a[a_addr[11:2]];

    always @(posedge clk) begin
        a_mem_rdata <= sram_a[a_mem_addr];
        if (a_valid && a_ready) begin
            log_a.push_back('{a_write, a_addr, a_wdata});
            if (a_write) regs_a[a_addr[11:2]] <= a_wdata;
        end
    end

    // ---------------- instance B: VERIFY=0, 4 entries ----------------
    logic        rst_b, start_b;
    logic        b_busy, b_done, b_error;
    logic [1:0]  b_err_idx;
    logic [2:0]  b_count;
    logic        b_mem_req;
    logic [1:0]  b_mem_addr;
    logic [63:0] b_mem_rdata;
    logic        b_valid, b_write;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_wstrb;
    logic [63:0] sram_b [0:3];
    txn_t        log_b [$];
    int          fetch_b [$];

    rv_iopmp_cfg_loader #(.NUM_WORDS(4), .VERIFY(0)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_b),
        .busy_o(b_busy), .done_o(b_done), .error_o(b_error),
        .err_idx_o(b_err_idx), .count_o(b_count),
        .mem_req_o(b_mem_req), .mem_addr_o(b_mem_addr), .mem_rdata_i(b_mem_rdata),
        .reg_valid_o(b_valid), .reg_write_o(b_write), .reg_addr_o(b_addr),
        .reg_wdata_o(b_wdata), .reg_wstrb_o(b_wstrb), .reg_ready_i(1'b1),
        .reg_rdata_i(32'h0), .reg_error_i(1'b0)
    );

    always @(posedge clk) begin
        b_mem_rdata <= sram_b[b_mem_addr];
        if (b_mem_req) fetch_b.push_back(int'(b_mem_addr));
        if (b_valid) log_b.push_back('{b_write, b_addr, b_wdata});
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_a(input int n, input int last_at);
        for (int i = 0; i < 64; i++) sram_a[i] = 64'h0;
        // entry 1 carries the reserved bit set; it must be ignored
        for (int i = 0; i < n; i++)
            sram_a[i] = {dat[i], adr[i][31:2], 1'(i == 1), 1'(i == last_at)};
    endtask

    task automatic start_pulse_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic run_a(input vec_t v);
        int base;
        int cyc;
        int done_cyc;
        txn_t t;
        load_a(v.n, v.last_at);
        a_err_en   = (v.err_wr >= 0);
        a_err_addr = (v.err_wr >= 0) ? adr[v.err_wr] : 32'h0;
        a_bad_rd   = v.bad_rd;
        a_hold     = 1'b0;
        base       = log_a.size();
        start_pulse_a();
        // now in cycle 1 after the start edge
        check("start_fetch", {a_mem_req, a_mem_addr, a_count, a_error}, {1'b1, 6'd0, 7'd0, 1'b0});
        cyc = 1;
        done_cyc = -1;
        while (cyc <= 300 && done_cyc < 0) begin
            if (a_done) done_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
                start_a = v.poke && (cyc == 2);
            end
        end
        start_a = 1'b0;
        check("done_cycle", done_cyc, v.exp_done);
        check("busy_in_done", a_busy, 1'b1);
        check("count", a_count, v.exp_count);
        check("error", a_error, v.exp_err);
        check("err_idx", a_err_idx, v.exp_err_idx);
        if (v.poke) start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("done_one_pulse", a_done, 1'b0);
        check("busy_fall", a_busy, 1'b0);
        @(negedge clk);
        check("no_restart", {a_busy, a_mem_req}, 2'b00);
        check("txn_count", log_a.size() - base, v.exp_txns);
        for (int j = 0; j < v.exp_txns && base + j < log_a.size(); j++) begin
            t = log_a[base + j];
            check("txn_addr", t.addr, adr[j / 2]);
            check("txn_dir", t.w, (j % 2) == 0);
            if (t.w) check("txn_wdata", t.data, dat[j / 2]);
        end
    endtask

    vec_t vecs [5];

    initial begin
        int base;
        int cyc;
        int done_cyc;

        //          n last err bad poke cnt err idx done txns
        vecs[0] = '{3, 2,  -1,  0,  0,   3,  0,  0,  16,  6};  // happy path
        vecs[1] = '{4, 3,   1,  0,  0,   1,  1,  1,   9,  3};  // write error on entry 1
        vecs[2] = '{1, 0,  -1,  1,  0,   0,  1,  0,   5,  2};  // readback mismatch on entry 0
        vecs[3] = '{1, 0,  -1,  0,  1,   1,  0,  0,   6,  2};  // single entry, start poked while busy/done
        vecs[4] = '{4, 3,  -1,  0,  0,   4,  0,  0,  21,  8};  // full run after reset

        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        check("reset_a_ctl", {a_busy, a_done, a_error, a_err_idx, a_count, a_mem_req,
                              a_mem_addr, a_valid, a_write, a_wstrb}, 64'h0);
        check("reset_a_bus", {a_addr, a_wdata}, 64'h0);
        check("reset_b", {b_busy, b_done, b_error, b_count, b_mem_req, b_valid, b_wstrb}, 64'h0);

        for (int k = 0; k < 4; k++) run_a(vecs[k]);

        // --- ready held low for 3 cycles on the write of entry 0 ---
        load_a(1, 0);
        a_err_en = 1'b0; a_bad_rd = 1'b0; a_hold = 1'b1;
        base = log_a.size();
        start_pulse_a();
        repeat (2) @(negedge clk);           // cycle 3: WRITE
        for (int k = 3; k <= 6; k++) begin
            start_a = (k == 4);              // ignored while busy
            if (k == 6) a_hold = 1'b0;
            check("stall_hold", {a_valid, a_write, a_wstrb, a_addr, a_wdata},
                  {1'b1, 1'b1, 4'hF, 32'h0, 32'h1});
            @(negedge clk);
        end
        start_a = 1'b0;
        check("stall_read", {a_valid, a_write, a_wstrb, a_addr}, {1'b1, 1'b0, 4'h0, 32'h0});
        repeat (2) @(negedge clk);           // cycle 9
        check("stall_done", {a_done, a_count, a_error}, {1'b1, 7'd1, 1'b0});
        check("stall_txns", log_a.size() - base, 2);
        if (log_a.size() - base == 2) check("stall_one_write", {log_a[base].w, log_a[base + 1].w}, 2'b10);
        repeat (2) @(negedge clk);

        // --- reset during a stalled write of entry 1 ---
        load_a(4, 3);
        a_hold = 1'b0;
        start_pulse_a();
        repeat (6) @(negedge clk);           // cycle 7: WAIT of entry 1
        a_hold = 1'b1;
        @(negedge clk);                      // cycle 8: WRITE of entry 1
        check("rst_in_write", {a_valid, a_write, a_addr}, {1'b1, 1'b1, 32'h800});
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("rst_idle", {a_valid, a_busy, a_done, a_mem_req}, 4'h0);
        a_hold = 1'b0;
        @(negedge clk);
        check("rst_no_done", {a_done, a_busy}, 2'b00);
        run_a(vecs[4]);

        // --- VERIFY=0, 4-entry table with no LAST bit ---
        for (int i = 0; i < 4; i++) sram_b[i] = {dat[i], adr[i][31:2], 2'b00};
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        cyc = 1;
        done_cyc = -1;
        while (cyc <= 100 && done_cyc < 0) begin
            if (b_done) done_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("b_done_cycle", done_cyc, 17);
        check("b_result", {b_count, b_error}, {3'd4, 1'b0});
        repeat (3) @(negedge clk);
        check("b_idle", {b_busy, b_done}, 2'b00);
        check("b_writes", log_b.size(), 4);
        for (int j = 0; j < 4 && j < log_b.size(); j++)
            check("b_txn", {log_b[j].w, log_b[j].addr, log_b[j].data}, {1'b1, adr[j], dat[j]});
        check("b_fetches", fetch_b.size(), 4);
        for (int j = 0; j < 4 && j < fetch_b.size(); j++)
            check("b_fetch_idx", fetch_b[j], j);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
